fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents {inst, pc, pc+4} with a valid/ready handshake to the decode stage.
- Handles redirects (branch/jump/jalr targets) by dropping in-flight responses.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem request/response handling, instruction FIFO to decode.
// Optional FETCH_MISALIGN_EN macro: misaligned redirects trap into a FAULT state instead of being aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        fetch_fault_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d, kill_q, kill_d, count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pcq_mem_q  [DEPTH];
  logic          grant, push, pop, misalign;
  logic [31:0]   redirect_tgt;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef FETCH_MISALIGN_EN
  assign redirect_tgt = redirect_pc_i;
  assign misalign     = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign fetch_fault_o = (state_q == FAULT);
`else
  assign redirect_tgt  = redirect_pc_i & 32'hFFFF_FFFC;
  assign misalign      = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  assign imem_addr_o   = fetch_pc_q;
  assign id_valid_o    = (count_q != '0);
  assign id_inst_o     = id_valid_o ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign id_pc_o       = id_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign id_pc_plus4_o = id_valid_o ? pc_mem_q[rd_ptr_q] + 32'd4 : 32'h0;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pcq_wr_d    = pcq_wr_q;
    pcq_rd_d    = pcq_rd_q;
    imem_req_o  = 1'b0;
    credit_used = {1'b0, outst_q} + {1'b0, count_q};

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     imem_req_o = !redirect_valid_i && (credit_used < (CW+1)'(DEPTH));
      FAULT:   imem_req_o = 1'b0;
      default: state_d = IDLE;
    endcase

    grant = imem_req_o && imem_gnt_i;
    push  = imem_rvalid_i && (kill_q == '0) && !redirect_valid_i;
    pop   = id_valid_o && id_ready_i && !redirect_valid_i;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pcq_wr_d   = ptr_inc(pcq_wr_q);
    end
    // Every response retires one PC-queue slot, killed or not, so the queue stays aligned
    if (imem_rvalid_i) pcq_rd_d = ptr_inc(pcq_rd_q);
    if (imem_rvalid_i && (kill_q != '0)) kill_d = kill_q - CW'(1);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    outst_d = outst_q + CW'(grant) - CW'(imem_rvalid_i);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_tgt;
      kill_d     = outst_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      if (misalign)              state_d = FAULT;
      else if (state_q == FAULT) state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (grant && (pcq_wr_q == PW'(gi))) pcq_mem_q[gi] <= fetch_pc_q;
      if (push && (wr_ptr_q == PW'(gi))) begin
        inst_mem_q[gi] <= imem_rdata_i;
        pc_mem_q[gi]   <= pcq_mem_q[pcq_rd_q];
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency and a scoreboard of granted PCs.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready, id_valid, fetch_fault;
  logic [31:0] id_inst, id_pc, id_pc_plus4;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .id_ready_i(id_ready), .id_valid_o(id_valid), .id_inst_o(id_inst),
    .id_pc_o(id_pc), .id_pc_plus4_o(id_pc_plus4), .fetch_fault_o(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       pend[$];
  logic [31:0] sb[$];
  int          n_err = 0, n_checks = 0, cyc = 0, mem_lat = 1, pops = 0;
  logic [31:0] exp_fetch, last_pop_pc, last_pop_p4, last_pop_inst;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    n_checks++;
    assert (obs === req_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, req_v);
    end
  endtask

  // One clock cycle: drive memory, model grants/pops against the scoreboard, advance to posedge+1.
  task automatic tick();
    logic [31:0] e;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    if (redirect_valid) chk("req_during_redirect", imem_req, 0);
    chk("credit_limit", 32'(sb.size() <= DEPTH), 1);
    if (imem_req && imem_gnt) begin
      chk("grant_addr", imem_addr, exp_fetch);
      pend.push_back('{addr: imem_addr, due: cyc + mem_lat});
      sb.push_back(imem_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (id_valid && id_ready && !redirect_valid) begin
      chk("pop_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", id_pc, e);
        chk("pop_inst", id_inst, memword(e));
        chk("pop_pc_plus4", id_pc_plus4, e + 32'd4);
      end
      $display("pop pc=%h inst=%h pc4=%h", id_pc, id_inst, id_pc_plus4);
      last_pop_pc   = id_pc;
      last_pop_p4   = id_pc_plus4;
      last_pop_inst = id_inst;
      pops++;
    end
    if (redirect_valid) begin
      sb.delete();
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_valid"}, id_valid, 0);
    chk({tag, "_inst"}, id_inst, NOP);
    chk({tag, "_pc"}, id_pc, 0);
    chk({tag, "_pc4"}, id_pc_plus4, 0);
    chk({tag, "_fault"}, fetch_fault, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!id_valid && n < 20) begin tick(); n++; end
    chk({tag, "_timeout"}, 32'(id_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p;
    rst = 1'b1; id_ready = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; last_pop_pc = 32'h1; last_pop_p4 = 32'h1;
    last_pop_inst = 32'h0; exp_fetch = RESET_PC;

    // Reset and first fetches
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst0");
    rst = 1'b0;
    chk("idle_req", imem_req, 0);
    tick();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 32'h100);
    chk("c1_valid", id_valid, 0);
    tick();
    chk("c2_addr", imem_addr, 32'h104);
    chk("c2_valid", id_valid, 0);
    tick();
    chk("c3_valid", id_valid, 1);
    chk("c3_pc", id_pc, 32'h100);
    chk("c3_pc4", id_pc_plus4, 32'h104);
    n = 0;
    while (pops < 2 && n < 10) begin tick(); n++; end
    chk("second_pop_pc", last_pop_pc, 32'h104);
    chk("second_pop_pc4", last_pop_p4, 32'h108);

    // Decode stall
    id_ready = 1'b0;
    repeat (5) begin
      tick();
      if (id_valid) chk("stall_hold_pc", id_pc, 32'h108);
    end
    chk("stall_valid", id_valid, 1);
    chk("stall_pc", id_pc, 32'h108);
    chk("stall_inst", id_inst, memword(32'h108));
    chk("stall_req_drop", imem_req, 0);
    id_ready = 1'b1;
    tick();
    chk("release_pop", last_pop_pc, 32'h108);
    repeat (8) tick();

    // Redirect with two requests in flight
    mem_lat = 3;
    n = 0;
    while (!(pend.size() == 2 && sb.size() == 2) && n < 20) begin tick(); n++; end
    chk("two_inflight", 32'(pend.size()), 2);
    redirect(32'h200);
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_valid", id_valid, 0);
    wait_valid("redir_wait");
    chk("redir_first_pc", id_pc, 32'h200);
    mem_lat = 1;
    repeat (4) tick();

    // Redirect coinciding with a response and a pop
    n = 0;
    while (!(id_valid && pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin tick(); n++; end
    chk("coincide_setup", 32'(id_valid && pend.size() > 0), 1);
    redirect(32'h40);
    chk("coincide_valid", id_valid, 0);
    chk("coincide_inst", id_inst, NOP);
    chk("coincide_pc", id_pc, 0);
    chk("coincide_pc4", id_pc_plus4, 0);
    wait_valid("coincide_wait");
    chk("coincide_next_pc", id_pc, 32'h40);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    n = 0;
    while (last_pop_pc != 32'hFFFF_FFFC && n < 30) begin tick(); n++; end
    chk("wrap_pop_pc", last_pop_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", last_pop_p4, 32'h0);
    p = pops; n = 0;
    while (pops == p && n < 10) begin tick(); n++; end
    chk("wrap_next_pc", last_pop_pc, 32'h0);
    chk("wrap_next_inst", last_pop_inst, memword(32'h0));

    // Reset mid-stream with one request outstanding
    n = 0;
    while (pend.size() != 1 && n < 10) begin tick(); n++; end
    chk("mid_outstanding", 32'(pend.size()), 1);
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    pend.delete(); sb.delete();
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fetch = RESET_PC;
    chk("rst_idle_req", imem_req, 0);
    repeat (3) tick();
    chk("rst_first_valid", id_valid, 1);
    chk("rst_first_pc", id_pc, RESET_PC);
    repeat (3) tick();

    // Misaligned redirect
    redirect(32'h202);
`ifdef FETCH_MISALIGN_EN
    chk("mis_fault", fetch_fault, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", id_valid, 0);
    repeat (3) tick();
    chk("mis_fault_hold", fetch_fault, 1);
    chk("mis_req_hold", imem_req, 0);
    redirect(32'h300);
    chk("mis_exit_fault", fetch_fault, 0);
    wait_valid("mis_resume");
    chk("mis_resume_pc", id_pc, 32'h300);
`else
    chk("mis_nofault", fetch_fault, 0);
    wait_valid("mis_aligned");
    chk("mis_aligned_pc", id_pc, 32'h200);
`endif
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
